// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-ported data memory between the pipeline MEM stage
// and a DMA burst port; the pipeline wins unless DMA has waited MAX_WAIT cycles.
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned LEN_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p_req,
   input  logic             p_we,
   input  logic [31:0]      p_addr,
   input  logic [31:0]      p_wdata,
   output logic [31:0]      p_rdata,
   output logic             p_stall,
   input  logic             d_start,
   input  logic             d_we,
   input  logic [31:0]      d_addr,
   input  logic [LEN_W-1:0] d_len,
   input  logic [31:0]      d_wdata,
   output logic [31:0]      d_rdata,
   output logic             d_beat,
   output logic             d_busy,
   output logic             d_done,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_di,
   output logic             mem_we,
   input  logic [31:0]      mem_do
);

   localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic              wr_latched_q, wr_latched_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              dma_grant;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cur_addr_q   <= '0;
         remaining_q  <= '0;
         wr_latched_q <= 1'b0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         remaining_q  <= remaining_d;
         wr_latched_q <= wr_latched_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      remaining_d  = remaining_q;
      wr_latched_d = wr_latched_q;
      wait_cnt_d   = wait_cnt_q;
      d_beat       = 1'b0;
      dma_grant    = !p_req || (wait_cnt_q == WAIT_MAX);

      unique case (state_q)
         IDLE: begin
            if (d_start) begin
               if (d_len != '0) begin
                  cur_addr_d   = d_addr;
                  remaining_d  = d_len;
                  wr_latched_d = d_we;
                  wait_cnt_d   = '0;
                  state_d      = BURST;
               end else begin
                  state_d = DONE;
               end
            end
         end
         BURST: begin
            // wait_cnt never exceeds WAIT_MAX: reaching it forces the grant
            if (dma_grant) begin
               d_beat      = 1'b1;
               cur_addr_d  = cur_addr_q + 32'd4;
               remaining_d = remaining_q - LEN_W'(1);
               wait_cnt_d  = '0;
               if (remaining_q == LEN_W'(1)) state_d = DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (d_beat) begin
         mem_a  = cur_addr_q;
         mem_di = d_wdata;
         mem_we = reset && wr_latched_q;
      end else begin
         mem_a  = p_addr;
         mem_di = p_wdata;
         mem_we = reset && p_req && p_we;
      end
   end

   assign p_stall = p_req && d_beat;
   assign p_rdata = mem_do;
   assign d_rdata = mem_do;
   assign d_busy  = (state_q == BURST);
   assign d_done  = (state_q == DONE);

endmodule
